// File: rtl/alpha_recursion_ctrl.sv
// Sequencer for the forward (alpha) recursion of the SISO decoder over one block of K steps.
// Latency: one step every 1+RD_LAT+L+1 cycles (L = row pipeline latency), one step in flight.
// Backpressure: none; waits on the eight row units and aborts on misalignment or timeout.
module alpha_recursion_ctrl #(
   parameter int DWIDTH   = 16,
   parameter int ROW_SIZE = 3072,
   parameter int ADDR_W   = $clog2(ROW_SIZE),
   parameter int RD_LAT   = 1,
   parameter int TIMEOUT  = 15
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic              o_init_en,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_calc_valid,
   output logic [ADDR_W-1:0] o_calc_addr,
   input  logic [7:0]        i_row_valid,
   input  logic [ADDR_W-1:0] i_row_addr,
   output logic              o_norm_en,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr
);

   // The DLY counter is two bits wide, so the read latency is bounded to 1..4.
   if (RD_LAT < 1 || RD_LAT > 4 || DWIDTH < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("alpha_recursion_ctrl: parameter out of range");
   end

   localparam int WCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0]   LEN_MIN  = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(ROW_SIZE);
   localparam logic [ADDR_W:0]   K_ONE    = (ADDR_W+1)'(1);
   localparam logic [1:0]        DLY_LAST = 2'(RD_LAT - 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, INIT, READ, DLY, WAIT, DONE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W:0]     k, k_nxt;
   logic [ADDR_W:0]     len_q, len_nxt;
   logic [1:0]          dly_cnt, dly_nxt;
   logic [WCNT_W-1:0]   wait_cnt, wait_nxt;
   logic                len_ok, row_hit;

   logic                busy_d, done_d, err_d, init_d, rd_d, calc_d, wr_d;
   logic [ADDR_W-1:0]   rd_addr_d, calc_addr_d, wr_addr_d;

   assign len_ok  = (i_len >= LEN_MIN) && (i_len <= LEN_MAX);
   assign row_hit = ({1'b0, i_row_addr} == k);

   // Next-state decode; every output is computed here and registered below.
   always_comb begin
      state_nxt   = state;
      k_nxt       = k;
      len_nxt     = len_q;
      dly_nxt     = dly_cnt;
      wait_nxt    = wait_cnt;
      done_d      = 1'b0;
      err_d       = o_err;
      init_d      = 1'b0;
      rd_d        = 1'b0;
      rd_addr_d   = '0;
      calc_d      = 1'b0;
      calc_addr_d = '0;
      wr_d        = 1'b0;
      wr_addr_d   = '0;
      case (state)
         IDLE: begin
            if (i_start) begin
               if (len_ok) begin
                  len_nxt   = i_len;
                  k_nxt     = K_ONE;
                  err_d     = 1'b0;
                  state_nxt = INIT;
               end else begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         INIT: begin
            init_d    = 1'b1;
            state_nxt = READ;
         end
         READ: begin
            rd_d      = 1'b1;
            rd_addr_d = ADDR_W'(k - K_ONE);
            dly_nxt   = '0;
            state_nxt = DLY;
         end
         DLY: begin
            if (dly_cnt == DLY_LAST) begin
               calc_d      = 1'b1;
               calc_addr_d = k[ADDR_W-1:0];
               wait_nxt    = '0;
               state_nxt   = WAIT;
            end else begin
               dly_nxt = dly_cnt + 2'd1;
            end
         end
         WAIT: begin
            // Row results are checked before the timeout so a late but
            // valid result on the final cycle is still committed.
            if (i_row_valid == 8'hFF) begin
               if (row_hit) begin
                  wr_d      = 1'b1;
                  wr_addr_d = k[ADDR_W-1:0];
                  k_nxt     = k + K_ONE;
                  state_nxt = ((k + K_ONE) == len_q) ? DONE : READ;
               end else begin
                  err_d     = 1'b1;
                  state_nxt = DONE;
               end
            end else if (i_row_valid != 8'h00) begin
               err_d     = 1'b1;
               state_nxt = DONE;
            end else if (wait_cnt == WAIT_MAX) begin
               err_d     = 1'b1;
               state_nxt = DONE;
            end else begin
               wait_nxt = wait_cnt + WCNT_W'(1);
            end
         end
         DONE: begin
            done_d    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Busy drops together with the done pulse, one cycle after DONE is entered.
      busy_d = (state_nxt != IDLE);
   end

   // State, step counter and block length.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         k        <= '0;
         len_q    <= '0;
         dly_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         k        <= k_nxt;
         len_q    <= len_nxt;
         dly_cnt  <= dly_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Registered outputs; strobes never share a cycle with a stale address.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_init_en    <= 1'b0;
         o_rd_en      <= 1'b0;
         o_rd_addr    <= '0;
         o_calc_valid <= 1'b0;
         o_calc_addr  <= '0;
         o_norm_en    <= 1'b0;
         o_wr_en      <= 1'b0;
         o_wr_addr    <= '0;
      end else begin
         o_busy       <= busy_d;
         o_done       <= done_d;
         o_err        <= err_d;
         o_init_en    <= init_d;
         o_rd_en      <= rd_d;
         o_rd_addr    <= rd_addr_d;
         o_calc_valid <= calc_d;
         o_calc_addr  <= calc_addr_d;
         o_norm_en    <= wr_d;
         o_wr_en      <= wr_d;
         o_wr_addr    <= wr_addr_d;
      end
   end

endmodule

// File: tb/tb_alpha_recursion_ctrl.sv
// Directed-plus-random bench for alpha_recursion_ctrl with a responding row-unit model.
// Expected address sequences and timing are derived from block length and row latency.
// Row results are returned by a separate process with per-step configurable faults.
module tb_alpha_recursion_ctrl;

   localparam int ROW  = 3072;
   localparam int AW   = $clog2(ROW);
   localparam int RDL  = 1;
   localparam int TOUT = 15;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          i_start;
   logic [AW:0]   i_len;
   logic          o_busy, o_done, o_err, o_init_en, o_rd_en, o_calc_valid;
   logic          o_norm_en, o_wr_en;
   logic [AW-1:0] o_rd_addr, o_calc_addr, o_wr_addr, i_row_addr;
   logic [7:0]    i_row_valid;

   alpha_recursion_ctrl #(
      .DWIDTH(16), .ROW_SIZE(ROW), .RD_LAT(RDL), .TIMEOUT(TOUT)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .i_start(i_start), .i_len(i_len),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_init_en(o_init_en),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_calc_valid(o_calc_valid),
      .o_calc_addr(o_calc_addr), .i_row_valid(i_row_valid), .i_row_addr(i_row_addr),
      .o_norm_en(o_norm_en), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr)
   );

   always #5 aclk = ~aclk;

   // Observation log written only by the monitor.
   int cyc = 0;
   int rd_q[$], calc_q[$], wr_q[$], rd_cyc_q[$];
   int init_cnt = 0, done_cnt = 0, norm_bad = 0, order_bad = 0;
   int last_rd_cyc = 0, last_rd_addr = 0, last_calc_cyc = 0;
   int done_cyc = 0, err_cyc = 0;
   logic prev_err = 1'b0;

   // Row-unit model configuration, written only by the main sequence.
   int misalign_step = -1, badaddr_step = -1, silent_step = -1, slow_step = -1;
   int fixed_lat = 0;
   int lat_q[$];

   int n_chk = 0, n_pass = 0;
   int start_cyc = 0;

   // Monitor: samples outputs 1 time unit after every rising edge.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         cyc++;
         if (o_init_en) init_cnt++;
         if (o_rd_en) begin
            rd_q.push_back(int'(o_rd_addr));
            rd_cyc_q.push_back(cyc);
            last_rd_cyc  = cyc;
            last_rd_addr = int'(o_rd_addr);
         end
         if (o_calc_valid) begin
            calc_q.push_back(int'(o_calc_addr));
            if (cyc - last_rd_cyc != RDL || int'(o_calc_addr) != last_rd_addr + 1) order_bad++;
            last_calc_cyc = cyc;
         end
         if (o_wr_en) wr_q.push_back(int'(o_wr_addr));
         if (o_norm_en != o_wr_en) norm_bad++;
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (o_busy) order_bad++;
         end
         if (o_err && !prev_err) err_cyc = cyc;
         prev_err = o_err;
      end
   end

   // Row-unit model: answers each launch after L cycles, with optional faults.
   initial begin
      int step, lat;
      i_row_valid = '0;
      i_row_addr  = '0;
      forever begin
         @(posedge aclk);
         #2;
         if (o_calc_valid) begin
            step = int'(o_calc_addr);
            if (step != silent_step) begin
               if (step == slow_step)  lat = 8;
               else if (fixed_lat > 0) lat = fixed_lat;
               else                    lat = int'($urandom_range(1, 3));
               lat_q.push_back(lat);
               repeat (lat) @(posedge aclk);
               #2;
               i_row_valid = (step == misalign_step) ? 8'h7F : 8'hFF;
               i_row_addr  = (step == badaddr_step) ? AW'(step + 1) : AW'(step);
               @(posedge aclk);
               #2;
               i_row_valid = '0;
               i_row_addr  = '0;
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #3;
   endtask

   function automatic longint outs_all();
      return longint'({o_busy, o_done, o_err, o_init_en, o_rd_en, o_rd_addr, o_calc_valid,
                       o_calc_addr, o_norm_en, o_wr_en, o_wr_addr});
   endfunction

   task automatic start(input int len);
      i_len     = (AW+1)'(len);
      i_start   = 1'b1;
      start_cyc = cyc;
      tick();
      i_start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base, input int budget);
      int t = 0;
      while (done_cnt == base && t < budget) begin
         tick();
         t++;
      end
      tick();
      tick();
      chk({tag, "_done_once"}, done_cnt - base, 1);
   endtask

   task automatic chk_seq(input string tag, input int q[$], input int base, input int first, input int n);
      int bad = 0;
      chk({tag, "_count"}, q.size() - base, n);
      for (int i = 0; i < n && base + i < q.size(); i++)
         if (q[base + i] != first + i) bad++;
      chk({tag, "_values"}, bad, 0);
   endtask

   // Legal block: K-1 steps, each read k-1 / launch k / write k, period 2+RD_LAT+L.
   task automatic run_legal(input string tag, input int kk, input bit mid_start);
      int b_init = init_cnt, b_rd = rd_q.size(), b_calc = calc_q.size(), b_wr = wr_q.size();
      int b_done = done_cnt, b_norm = norm_bad, b_ord = order_bad, b_lat = lat_q.size();
      int b_rdc = rd_cyc_q.size();
      int pbad = 0;
      start(kk);
      chk({tag, "_busy"}, o_busy, 1);
      if (mid_start) begin
         tick(); tick(); tick();
         i_len   = (AW+1)'(1);
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
      end
      wait_done(tag, b_done, kk * 12 + 60);
      chk({tag, "_init"}, init_cnt - b_init, 1);
      chk_seq({tag, "_rd"},   rd_q,   b_rd,   0, kk - 1);
      chk_seq({tag, "_calc"}, calc_q, b_calc, 1, kk - 1);
      chk_seq({tag, "_wr"},   wr_q,   b_wr,   1, kk - 1);
      chk({tag, "_norm"}, norm_bad - b_norm, 0);
      chk({tag, "_order"}, order_bad - b_ord, 0);
      chk({tag, "_err"}, o_err, 0);
      for (int i = 0; i + 1 < kk - 1; i++)
         if (b_rdc + i + 1 < rd_cyc_q.size() && b_lat + i < lat_q.size())
            if (rd_cyc_q[b_rdc + i + 1] - rd_cyc_q[b_rdc + i] != 2 + RDL + lat_q[b_lat + i]) pbad++;
      chk({tag, "_period"}, pbad, 0);
   endtask

   task automatic run_illegal(input string tag, input int len);
      int b_init = init_cnt, b_rd = rd_q.size(), b_done = done_cnt;
      start(len);
      chk({tag, "_done_cycle"}, done_cyc, start_cyc + 1);
      tick(); tick();
      chk({tag, "_done_once"}, done_cnt - b_done, 1);
      chk({tag, "_no_init"}, init_cnt - b_init, 0);
      chk({tag, "_no_rd"}, rd_q.size() - b_rd, 0);
      chk({tag, "_err"}, o_err, 1);
      chk({tag, "_busy"}, o_busy, 0);
   endtask

   task automatic run_abort(input string tag, input int kk, input int n_wr);
      int b_wr = wr_q.size(), b_done = done_cnt;
      start(kk);
      wait_done(tag, b_done, 300);
      chk_seq({tag, "_wr"}, wr_q, b_wr, 1, n_wr);
      chk({tag, "_err"}, o_err, 1);
      chk({tag, "_busy"}, o_busy, 0);
   endtask

   initial begin
      int b_wr, b_done, b_calc, t;
      aresetn = 1'b0;
      i_start = 1'b0;
      i_len   = '0;
      tick(); tick(); tick();
      chk("reset_outputs", outs_all(), 0);
      aresetn = 1'b1;
      tick(); tick();
      chk("idle_outputs", outs_all(), 0);

      fixed_lat = 3;
      run_legal("nominal", 4, 1'b0);
      fixed_lat = 0;

      for (int r = 0; r < 3; r++)
         run_legal("random", int'($urandom_range(2, 40)), 1'b1);

      run_illegal("len1", 1);
      run_illegal("len3073", ROW + 1);
      run_legal("err_clear", 2, 1'b0);

      misalign_step = 2;
      run_abort("misalign", 6, 1);
      misalign_step = -1;

      badaddr_step = 3;
      run_abort("bad_addr", 6, 2);
      badaddr_step = -1;

      silent_step = 1;
      run_abort("timeout", 5, 0);
      chk("timeout_cycles", err_cyc - last_calc_cyc, TOUT);
      chk("timeout_done_next", done_cyc - err_cyc, 1);
      silent_step = -1;

      // Reset while step 5 is waiting; its late result must be ignored.
      slow_step = 5;
      b_wr   = wr_q.size();
      b_done = done_cnt;
      b_calc = calc_q.size();
      start(10);
      t = 0;
      while (!(calc_q.size() > b_calc && calc_q[$] == 5) && t < 200) begin
         tick();
         t++;
      end
      chk("rst_reached_k5", (calc_q.size() > b_calc) ? calc_q[$] : -1, 5);
      tick(); tick();
      aresetn = 1'b0;
      tick();
      chk("rst_outputs", outs_all(), 0);
      tick();
      aresetn = 1'b1;
      repeat (12) tick();
      chk("rst_wr_count", wr_q.size() - b_wr, 4);
      chk("rst_idle", outs_all(), 0);
      chk("rst_no_done", done_cnt - b_done, 0);
      slow_step = -1;
      run_legal("post_reset", 4, 1'b0);

      b_wr = wr_q.size();
      run_legal("maxlen", ROW, 1'b0);
      chk("maxlen_last_wr", (wr_q.size() > b_wr) ? wr_q[$] : -1, ROW - 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
